// File: rtl/xup_debounce_vector.sv
// -----------------------------------------------------------------------------
// xup_debounce_vector
//
// Per-bit synchronizer and debouncer for raw board inputs such as slide
// switches and push-buttons. Each bit passes through a two-flop synchronizer.
// A per-bit stability counter then accepts a new level only after it has
// persisted for DEBOUNCE_CYCLES consecutive clock cycles. The clean levels feed
// the XUP vector gate primitives (for example the a/b operands of
// xup_and_vector).
//
// Parameters:
//   SIZE            number of independent input bits
//   CNT_WIDTH       width of each per-bit stability counter
//   DEBOUNCE_CYCLES cycles a new level must persist before it is accepted;
//                   must satisfy 1 <= DEBOUNCE_CYCLES <= 2**CNT_WIDTH
//
// Ports:
//   clk    in   1     system clock, all logic on the rising edge
//   reset  in   1     synchronous, active-high reset
//   a      in   SIZE  raw asynchronous inputs
//   y      out  SIZE  debounced level, registered
//   rise   out  SIZE  one-cycle strobe when y[i] goes 0->1
//   fall   out  SIZE  one-cycle strobe when y[i] goes 1->0
//
// Optional feature macro: XUP_DEBOUNCE_EDGE_EN
//   defined   -> rise/fall are registered strobes that are visible in the same
//                cycle as the new y value
//   undefined -> rise/fall are tied to 0 and no strobe registers exist; the
//                port list is the same in both builds
// -----------------------------------------------------------------------------
module xup_debounce_vector #(
  parameter int SIZE            = 2,
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] a,
  output logic [SIZE-1:0] y,
  output logic [SIZE-1:0] rise,
  output logic [SIZE-1:0] fall
);

  // Terminal count. It is truncated to the counter width, so a window of
  // exactly 2**CNT_WIDTH cycles ends at the all-ones count.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SIZE-1:0]      s1;
  logic [SIZE-1:0]      s2;
  logic [SIZE-1:0]      y_next;
  logic [CNT_WIDTH-1:0] cnt      [SIZE];
  logic [CNT_WIDTH-1:0] cnt_next [SIZE];

  // Any agreement between the synchronized input and the accepted level
  // clears the counter. A bounce back to the old level therefore restarts the
  // full window. The counter is also cleared on acceptance, so it never wraps.
  always_comb begin
    y_next = y;
    for (int i = 0; i < SIZE; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != y[i]) begin
        if (cnt[i] == CNT_LAST) begin
          y_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // The two synchronizer stages sit back to back with no logic between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      y  <= '0;
      for (int i = 0; i < SIZE; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= a;
      s2 <= s1;
      y  <= y_next;
      for (int i = 0; i < SIZE; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef XUP_DEBOUNCE_EDGE_EN
  logic [SIZE-1:0] rise_q;
  logic [SIZE-1:0] fall_q;

  // The strobes are registered on the same edge that updates y, so they line
  // up with the first cycle in which the new level is visible. Only y_next
  // can differ from y, so rise and fall are never high together for one bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= y_next & ~y;
      fall_q <= ~y_next & y;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_xup_debounce_vector.sv
// -----------------------------------------------------------------------------
// tb_xup_debounce_vector
//
// Directed self-checking bench for xup_debounce_vector. The main instance uses
// SIZE=2, CNT_WIDTH=4, DEBOUNCE_CYCLES=4. A second instance uses
// DEBOUNCE_CYCLES=1. Every expected value below is hand-derived. Inputs change
// 1 ns after a rising edge, and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_xup_debounce_vector;

  logic       clk;
  logic       reset;
  logic [1:0] a;
  logic [1:0] y;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] a1;
  logic [1:0] y1;
  logic [1:0] rise1;
  logic [1:0] fall1;

  int checks = 0;
  int errors = 0;

  xup_debounce_vector #(.SIZE(2), .CNT_WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .a(a), .y(y), .rise(rise), .fall(fall)
  );

  xup_debounce_vector #(.SIZE(2), .CNT_WIDTH(4), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .a(a1), .y(y1), .rise(rise1), .fall(fall1)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected strobe value: the strobe when the edge feature is built in,
  // otherwise always zero.
  function automatic logic [1:0] ed(input logic [1:0] v);
`ifdef XUP_DEBOUNCE_EDGE_EN
    return v;
`else
    return 2'b00;
`endif
  endfunction

  // Advance one rising edge, then settle 1 ns past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the raw inputs and reset for the next edge.
  task automatic applyStimulus(input logic [1:0] av, input logic rv);
    a     = av;
    reset = rv;
  endtask

  // Compare one observed value against its hand-derived expectation.
  task automatic checkOutput(input string tag, input logic [1:0] obs,
                             input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check y, rise and fall of the main instance together.
  task automatic checkMain(input string tag, input logic [1:0] ey,
                           input logic [1:0] er, input logic [1:0] ef);
    checkOutput({tag, ".y"}, y, ey);
    checkOutput({tag, ".rise"}, rise, er);
    checkOutput({tag, ".fall"}, fall, ef);
  endtask

  initial begin
    a1 = 2'b00;
    applyStimulus(2'b11, 1'b1);

    // Reset held for 3 edges while the inputs are high.
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkMain($sformatf("reset_hold%0d", i), 2'b00, 2'b00, 2'b00);
    end
    // After release, y=11 appears on the 6th edge, and rise pulses once.
    applyStimulus(2'b11, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      checkMain($sformatf("reset_release_e%0d", i),
                (i >= 6) ? 2'b11 : 2'b00,
                (i == 6) ? ed(2'b11) : 2'b00, 2'b00);
    end

    // Reset while y=11: y clears and no strobe is produced.
    applyStimulus(2'b00, 1'b1);
    cycle();
    checkMain("reset_no_strobe", 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b00, 1'b0);
    cycle();
    checkMain("idle", 2'b00, 2'b00, 2'b00);

    // Clean step on bit 0. Bit 1 must stay at 0.
    applyStimulus(2'b01, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      checkMain($sformatf("clean_e%0d", i),
                (i >= 6) ? 2'b01 : 2'b00,
                (i == 6) ? ed(2'b01) : 2'b00, 2'b00);
    end

    // Return to a clean all-zero state.
    applyStimulus(2'b00, 1'b1);
    cycle();
    applyStimulus(2'b00, 1'b0);
    cycle();
    checkMain("pre_bounce", 2'b00, 2'b00, 2'b00);

    // Bounce on bit 0 for 10 cycles (1,0,1,0,...). It must be rejected.
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 2'b01 : 2'b00, 1'b0);
      cycle();
      checkOutput($sformatf("bounce_c%0d.y", i), y, 2'b00);
    end
    // Then hold 1. It is accepted 6 edges after the first stable sample.
    applyStimulus(2'b01, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      checkMain($sformatf("bounce_settle_e%0d", i),
                (i >= 6) ? 2'b01 : 2'b00,
                (i == 6) ? ed(2'b01) : 2'b00, 2'b00);
    end

    // Raise bit 1 so that y=11.
    applyStimulus(2'b11, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      checkMain($sformatf("raise_b1_e%0d", i),
                (i >= 6) ? 2'b11 : 2'b01,
                (i == 6) ? ed(2'b10) : 2'b00, 2'b00);
    end

    // Three-cycle glitch low on bit 1. It is too short to be accepted.
    applyStimulus(2'b01, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkMain($sformatf("glitch_low%0d", i), 2'b11, 2'b00, 2'b00);
    end
    applyStimulus(2'b11, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      cycle();
      checkMain($sformatf("glitch_after%0d", i), 2'b11, 2'b00, 2'b00);
    end

    // Reset mid-count: bit 0 rises, and reset is pulsed on the 4th edge.
    applyStimulus(2'b00, 1'b1);
    cycle();
    applyStimulus(2'b00, 1'b0);
    cycle();
    applyStimulus(2'b01, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checkOutput($sformatf("midcount_c%0d.y", i), y, 2'b00);
    end
    applyStimulus(2'b01, 1'b1);
    cycle();
    checkMain("midcount_reset", 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      checkMain($sformatf("midcount_restart_e%0d", i),
                (i >= 6) ? 2'b01 : 2'b00,
                (i == 6) ? ed(2'b01) : 2'b00, 2'b00);
    end

    // Fall on bit 0 with the standard window.
    applyStimulus(2'b00, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      cycle();
      checkMain($sformatf("fall_e%0d", i),
                (i >= 6) ? 2'b00 : 2'b01, 2'b00,
                (i == 6) ? ed(2'b01) : 2'b00);
    end

    // DEBOUNCE_CYCLES=1: 3-edge latency, rising and then falling.
    a1 = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checkOutput($sformatf("d1_rise_e%0d.y", i), y1,
                  (i >= 3) ? 2'b01 : 2'b00);
      checkOutput($sformatf("d1_rise_e%0d.rise", i), rise1,
                  (i == 3) ? ed(2'b01) : 2'b00);
    end
    a1 = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checkOutput($sformatf("d1_fall_e%0d.y", i), y1,
                  (i >= 3) ? 2'b00 : 2'b01);
      checkOutput($sformatf("d1_fall_e%0d.fall", i), fall1,
                  (i == 3) ? ed(2'b01) : 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xup_debounce_vector.md
Name: xup_debounce_vector

Overview:
- Per-bit synchronizer and debouncer for a vector of raw board inputs (Basys3 slide switches, push-buttons).
- Sits directly upstream of xup_and_vector and the other XUP vector gate primitives, and drives their a/b operands with clean, glitch-free, clock-domain-safe levels.
- Optional single-cycle rise/fall strobes per bit for downstream counters and FSMs.

Parameters:
- SIZE, 2, number of independent input bits.
- CNT_WIDTH, 20, width of each per-bit stability counter.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a new level must persist before it is accepted (10 ms at 100 MHz). Must satisfy 1 <= DEBOUNCE_CYCLES <= 2^CNT_WIDTH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  SIZE  raw asynchronous inputs (switches/buttons).
- y  output  SIZE  debounced level, registered.
- rise  output  SIZE  one-cycle strobe when y[i] goes 0->1 (see Optional Feature).
- fall  output  SIZE  one-cycle strobe when y[i] goes 1->0 (see Optional Feature).

Behaviour:
- Reset, sampled on a clk edge with reset=1: both synchronizer stages, all counters, y, rise and fall clear to 0. Reset has priority over every other action.
- Synchronizer: per bit, a 2-flop chain s1[i] <= a[i], s2[i] <= s1[i]. No logic sits between the stages.
- Per-bit counter cnt[i] (CNT_WIDTH bits), evaluated each edge:
  - s2[i] == y[i]: cnt[i] <= 0.
  - s2[i] != y[i] and cnt[i] == DEBOUNCE_CYCLES-1: y[i] <= s2[i], cnt[i] <= 0.
  - otherwise: cnt[i] <= cnt[i]+1.
- Counter arithmetic: unsigned compare against DEBOUNCE_CYCLES-1 truncated to CNT_WIDTH. The counter never wraps, because it is cleared on acceptance or on agreement.
- Latency: if a[i] changes and stays stable, s1 captures it at edge k. y[i] updates at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges counting edge k as the first.
- Bounce rejection: any return of s2[i] to the current y[i] before acceptance clears cnt[i]. The full DEBOUNCE_CYCLES window must then elapse again.
- Bits are fully independent. Simultaneous changes on several bits are each accepted per their own counter; no cross-bit interaction.
- Reset mid-count: the count is discarded and y returns to 0. After reset is released, inputs held high take DEBOUNCE_CYCLES+2 edges to appear on y, and rise then pulses.
- DEBOUNCE_CYCLES == 1: y follows s2 one edge later, so total latency is 3 edges.
- Outputs y, rise and fall are registered only; no combinational path from a to any output.

Optional Feature:
- Macro: XUP_DEBOUNCE_EDGE_EN.
- Defined:
  - rise[i] <= 1 for exactly the one cycle following the edge at which y[i] is updated 0->1; fall[i] likewise for 1->0.
  - rise and fall are registered and assert in the same cycle the new y value is first visible.
  - Never both high for one bit.
  - Reset clears them; the reset itself generates no strobe.
- Undefined: rise and fall are tied to constant 0 and no edge-detect registers are synthesized. Ports remain, so the port list is identical in both builds.

Test Plan (SIZE=2, CNT_WIDTH=4, DEBOUNCE_CYCLES=4 unless noted):
- Reset: a=2'b11, reset=1 for 3 edges -> y=00, rise=00, fall=00 throughout. Release reset -> y=11 exactly 6 edges later; with EDGE_EN, rise=11 for that one cycle only.
- Clean step: a[0] 0->1 sampled at edge k, held -> y[0]=1 after edge k+5, not before. y[1] unchanged.
- Bounce: a[0] toggles 1,0,1,0 on successive cycles for 10 cycles, then holds 1 -> y[0] stays 0 during the bounce and goes 1 six edges after the final stable sample.
- Glitch: y[1]=1, a[1] drops to 0 for 3 cycles then returns to 1 -> y[1] stays 1, fall[1] never asserts.
- Reset mid-count: a[0] rises, reset pulsed one cycle at edge k+3 -> y[0]=0 and the count restarts. y[0]=1 at 6 edges after reset deassertion.
- Build without XUP_DEBOUNCE_EDGE_EN: repeat the clean-step scenario -> rise and fall remain 00 always, y timing is identical. DEBOUNCE_CYCLES=1 variant -> 3-edge latency.
